// File: rtl/rv32i_types.sv
`default_nettype none
// rv32i_types: shared RV32 decode types plus the multiply/divide unit's state, iteration count and helpers.
package rv32i_types;

  localparam int MULDIV_XLEN  = 32;
  localparam int MULDIV_ITERS = MULDIV_XLEN;

  typedef enum logic [4:0] {
    alu_add, alu_sub, alu_sll, alu_slt, alu_sltu, alu_xor, alu_srl, alu_sra,
    alu_or, alu_and,
    alu_mul, alu_mulh, alu_mulhsu, alu_mulhu,
    alu_div, alu_divu, alu_rem, alu_remu
  } alu_ops;

  typedef enum logic [1:0] {IDLE, PREP, CALC, FIN} muldiv_state_t;

  function automatic logic is_mul_op(input alu_ops op);
    return op inside {alu_mul, alu_mulh, alu_mulhsu, alu_mulhu};
  endfunction

  function automatic logic is_div_op(input alu_ops op);
    return op inside {alu_div, alu_divu, alu_rem, alu_remu};
  endfunction

  function automatic logic [MULDIV_XLEN-1:0] neg_word(input logic [MULDIV_XLEN-1:0] x, input logic en);
    return en ? -x : x;
  endfunction

  function automatic logic [2*MULDIV_XLEN-1:0] neg_dword(input logic [2*MULDIV_XLEN-1:0] x, input logic en);
    return en ? -x : x;
  endfunction

  // Unsigned magnitude; the most negative value maps onto itself, which is the correct unsigned magnitude.
  function automatic logic [MULDIV_XLEN-1:0] mag(input logic [MULDIV_XLEN-1:0] x, input logic sgn);
    return neg_word(x, sgn & x[MULDIV_XLEN-1]);
  endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_unit_if.sv
`default_nettype none
// muldiv_unit_if: request/response bundle between the execute stage and muldiv_unit.
interface muldiv_unit_if #(
  parameter int XLEN = rv32i_types::MULDIV_XLEN
) ();
  import rv32i_types::*;

  logic            start;
  logic            kill;
  alu_ops          aluop;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (output start, kill, aluop, a, b, input busy, done, result);
  modport slave  (input start, kill, aluop, a, b, output busy, done, result);
endinterface
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// muldiv_unit: iterative RV32M unit, radix-2 shift-add multiply and restoring divide with final sign fix-up.
// Define MULDIV_FAST_MUL_EN to compute multiplies in a single cycle in PREP instead of iterating.
module muldiv_unit
  import rv32i_types::*;
#(
  parameter int XLEN = MULDIV_XLEN
) (
  input logic          clk,
  input logic          rst_n,
  muldiv_unit_if.slave mdu
);

  localparam int ITERS = XLEN;
  localparam int CW    = $clog2(ITERS);

  muldiv_state_t     state, state_nxt;
  alu_ops            op;
  logic [XLEN-1:0]   opa, opb, shreg, dvsr, special_val, result;
  logic [2*XLEN-1:0] acc, mcand;
  logic [CW-1:0]     cnt;
  logic              neg_q, neg_r, special, done;

  logic              accept, div_op, a_signed, b_signed, sa, sb, div_zero, ovf, go_fin;
  logic [XLEN:0]     rem_sh, diff;
  logic [XLEN-1:0]   rem_new, quot_fix, rem_fix, fin_val;
  logic [2*XLEN-1:0] prod_fix;

`ifdef MULDIV_FAST_MUL_EN
  logic signed [2*XLEN+1:0] fast_prod;
  logic                     unused_fast_hi;
  assign fast_prod      = $signed({sa, opa}) * $signed({sb, opb});
  assign unused_fast_hi = ^fast_prod[2*XLEN+1:2*XLEN];
`endif

  assign mdu.busy   = (state != IDLE);
  assign mdu.done   = done;
  assign mdu.result = result;

  always_comb begin
    accept   = mdu.start && !mdu.kill && (is_mul_op(mdu.aluop) || is_div_op(mdu.aluop));
    div_op   = is_div_op(op);
    a_signed = op inside {alu_mulh, alu_mulhsu, alu_div, alu_rem};
    b_signed = op inside {alu_mulh, alu_div, alu_rem};
    sa       = a_signed & opa[XLEN-1];
    sb       = b_signed & opb[XLEN-1];
    div_zero = (opb == '0);
    ovf      = (op inside {alu_div, alu_rem}) && (opa == {1'b1, {(XLEN-1){1'b0}}}) && (&opb);
`ifdef MULDIV_FAST_MUL_EN
    go_fin   = div_op ? (div_zero || ovf) : 1'b1;
`else
    go_fin   = div_op && (div_zero || ovf);
`endif
    // Restoring step: remainder sits in acc low half, dividend bits stream out of shreg's MSB.
    rem_sh   = {acc[XLEN-1:0], shreg[XLEN-1]};
    diff     = rem_sh - {1'b0, dvsr};
    rem_new  = diff[XLEN] ? rem_sh[XLEN-1:0] : diff[XLEN-1:0];
    prod_fix = neg_dword(acc, neg_q);
    quot_fix = neg_word(shreg, neg_q);
    rem_fix  = neg_word(acc[XLEN-1:0], neg_r);
    if (special) begin
      fin_val = special_val;
    end else begin
      case (op)
        alu_mul:                        fin_val = prod_fix[XLEN-1:0];
        alu_mulh, alu_mulhsu, alu_mulhu: fin_val = prod_fix[2*XLEN-1:XLEN];
        alu_div, alu_divu:              fin_val = quot_fix;
        default:                        fin_val = rem_fix;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    if (mdu.kill) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (accept) state_nxt = PREP;
        PREP:    state_nxt = go_fin ? FIN : CALC;
        CALC:    if (cnt == CW'(ITERS-1)) state_nxt = FIN;
        FIN:     state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op <= alu_add; opa <= '0; opb <= '0; shreg <= '0; dvsr <= '0;
      acc <= '0; mcand <= '0; cnt <= '0; neg_q <= 1'b0; neg_r <= 1'b0;
      special <= 1'b0; special_val <= '0; result <= '0; done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (!mdu.kill) begin
        case (state)
          IDLE: if (accept) begin
            op  <= mdu.aluop;
            opa <= mdu.a;
            opb <= mdu.b;
          end
          PREP: begin
            cnt         <= '0;
            acc         <= '0;
            neg_q       <= sa ^ sb;
            neg_r       <= sa;
            special     <= div_op && (div_zero || ovf);
            special_val <= (op inside {alu_div, alu_divu}) ? (div_zero ? '1 : opa)
                                                           : (div_zero ? opa : '0);
            if (div_op) begin
              shreg <= mag(opa, a_signed);
              dvsr  <= mag(opb, b_signed);
            end else begin
`ifdef MULDIV_FAST_MUL_EN
              acc   <= fast_prod[2*XLEN-1:0];
              neg_q <= 1'b0;
`endif
              mcand <= {{XLEN{1'b0}}, mag(opa, a_signed)};
              shreg <= mag(opb, b_signed);
            end
          end
          CALC: begin
            cnt <= cnt + 1'b1;
            if (div_op) begin
              acc   <= {{XLEN{1'b0}}, rem_new};
              shreg <= {shreg[XLEN-2:0], ~diff[XLEN]};
            end else begin
              if (shreg[0]) acc <= acc + mcand;
              mcand <= mcand << 1;
              shreg <= shreg >> 1;
            end
          end
          FIN: begin
            result <= fin_val;
            done   <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// tb_muldiv_unit: directed vectors with hand-computed results and latencies for muldiv_unit.
module tb_muldiv_unit;
  import rv32i_types::*;

  localparam int XLEN    = 32;
  localparam int DIV_LAT = XLEN + 2;
`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 2;
`else
  localparam int MUL_LAT = XLEN + 2;
`endif

  logic   clk   = 1'b0;
  logic   rst_n = 1'b0;
  int     n_checks = 0;
  int     n_errors = 0;
  longint t_done;
  longint t_first;

  muldiv_unit_if #(.XLEN(XLEN)) mdu_if ();
  muldiv_unit #(.XLEN(XLEN)) dut (.clk(clk), .rst_n(rst_n), .mdu(mdu_if));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Issues one op, optionally pokes a stray start mid-flight, and checks result, latency and busy.
  task automatic run_op(input string tag, input alu_ops op, input logic [31:0] av, input logic [31:0] bv,
                        input logic [31:0] exp, input int exp_lat, input bit poke);
    int lat;
    bit got;
    bit busy_ok;
    @(negedge clk);
    mdu_if.start = 1'b1; mdu_if.aluop = op; mdu_if.a = av; mdu_if.b = bv;
    @(posedge clk); #1;
    mdu_if.start = 1'b0;
    busy_ok = mdu_if.busy;
    lat = 0;
    got = 1'b0;
    while (!got && lat < 100) begin
      if (poke && lat == 5) begin
        @(negedge clk);
        mdu_if.start = 1'b1; mdu_if.aluop = alu_mul; mdu_if.a = 32'd3; mdu_if.b = 32'd3;
      end
      @(posedge clk); lat++; #1;
      mdu_if.start = 1'b0;
      if (mdu_if.done) got = 1'b1;
      else if (!mdu_if.busy) busy_ok = 1'b0;
    end
    t_done = $time;
    check({tag, " done"}, 32'(got), 32'd1);
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check({tag, " busy"}, 32'(busy_ok), 32'd1);
    check({tag, " result"}, mdu_if.result, exp);
  endtask

  initial begin
    bit seen;
    mdu_if.start = 1'b0; mdu_if.kill = 1'b0; mdu_if.aluop = alu_add;
    mdu_if.a = '0; mdu_if.b = '0;
    #12;
    check("reset busy", 32'(mdu_if.busy), 32'd0);
    check("reset done", 32'(mdu_if.done), 32'd0);
    check("reset result", mdu_if.result, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    run_op("mul 7*-3", alu_mul, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_LAT, 1'b0);
    @(posedge clk); #1;
    check("done pulse width", 32'(mdu_if.done), 32'd0);

    run_op("mulhu", alu_mulhu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT, 1'b0);
    run_op("mulh", alu_mulh, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, MUL_LAT, 1'b0);
    run_op("mulhsu", alu_mulhsu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_LAT, 1'b0);
    run_op("mul -1*-1", alu_mul, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, MUL_LAT, 1'b0);

    run_op("divu 5/0", alu_divu, 32'd5, 32'd0, 32'hFFFF_FFFF, 2, 1'b0);
    run_op("remu 5/0", alu_remu, 32'd5, 32'd0, 32'd5, 2, 1'b0);
    run_op("div ovf", alu_div, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2, 1'b0);
    run_op("rem ovf", alu_rem, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 2, 1'b0);

    run_op("div -7/2", alu_div, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, DIV_LAT, 1'b0);
    run_op("rem -7/2", alu_rem, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, DIV_LAT, 1'b0);
    run_op("divu", alu_divu, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, DIV_LAT, 1'b0);
    run_op("remu", alu_remu, 32'hFFFF_FFF9, 32'd2, 32'd1, DIV_LAT, 1'b0);

    // Kill on the 10th CALC edge (edge E+11).
    @(negedge clk);
    mdu_if.start = 1'b1; mdu_if.aluop = alu_div; mdu_if.a = 32'd100; mdu_if.b = 32'd7;
    @(posedge clk); #1;
    mdu_if.start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk); mdu_if.kill = 1'b1;
    @(posedge clk); #1;
    mdu_if.kill = 1'b0;
    check("kill busy", 32'(mdu_if.busy), 32'd0);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (mdu_if.done) seen = 1'b1;
    end
    check("kill no done", 32'(seen), 32'd0);
    check("kill result kept", mdu_if.result, 32'd1);

    run_op("divu with stray start", alu_divu, 32'd100, 32'd7, 32'd14, DIV_LAT, 1'b1);

    @(negedge clk);
    mdu_if.start = 1'b1; mdu_if.aluop = alu_add; mdu_if.a = 32'd9; mdu_if.b = 32'd9;
    @(posedge clk); #1;
    mdu_if.start = 1'b0;
    check("add ignored busy", 32'(mdu_if.busy), 32'd0);
    seen = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      if (mdu_if.done || mdu_if.busy) seen = 1'b1;
    end
    check("add ignored activity", 32'(seen), 32'd0);
    check("add ignored result", mdu_if.result, 32'd14);

    // Asynchronous reset mid-CALC.
    @(negedge clk);
    mdu_if.start = 1'b1; mdu_if.aluop = alu_divu; mdu_if.a = 32'd1000; mdu_if.b = 32'd3;
    @(posedge clk); #1;
    mdu_if.start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk); rst_n = 1'b0;
    #1;
    check("midreset busy", 32'(mdu_if.busy), 32'd0);
    check("midreset done", 32'(mdu_if.done), 32'd0);
    check("midreset result", mdu_if.result, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    run_op("b2b first", alu_mul, 32'h1234_5678, 32'h0000_0010, 32'h2345_6780, MUL_LAT, 1'b0);
    t_first = t_done;
    run_op("b2b second", alu_mul, 32'd1000, 32'd1000, 32'h000F_4240, MUL_LAT, 1'b0);
    check("b2b spacing", 32'((t_done - t_first) / 10), 32'(MUL_LAT + 1));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
